// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel type, capture states and default geometry for the VGA capture path
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  typedef logic [23:0] pixel_t;
  typedef enum logic [1:0] {SEEK, ARMED, CAPTURE} cap_state_t;
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return &v ? v : v + 11'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: input register with polarity-normalised edge detect for hsync, vsync and valid
module vga_sync_edge
  import vga_pkg::*;
#(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hsync,
  input  logic   vsync,
  input  logic   valid,
  input  pixel_t pix_in,
  output pixel_t pix,
  output logic   vld,
  output logic   vld_rise,
  output logic   vld_fall,
  output logic   hs_rise,
  output logic   vs_rise
);
  logic hs_q, vs_q, vld_q, hs_d, vs_d;
  pixel_t pix_q;
  // sample inputs; syncs are normalised so 1 always means the active level
  always_ff @(posedge clk)
    if (reset) {hs_q, vs_q, vld_q, pix_q} <= '0;
    else {hs_q, vs_q, vld_q, pix_q} <= {hsync ~^ SYNC_POL, vsync ~^ SYNC_POL, valid, pix_in};
  // second stage keeps levels and their edge flags aligned to the same cycle
  always_ff @(posedge clk)
    if (reset) {hs_d, vs_d, vld, pix, vld_rise, vld_fall, hs_rise, vs_rise} <= '0;
    else begin
      hs_d     <= hs_q;
      vs_d     <= vs_q;
      vld      <= vld_q;
      pix      <= pix_q;
      vld_rise <= vld_q & ~vld;
      vld_fall <= ~vld_q & vld;
      hs_rise  <= hs_q & ~hs_d;
      vs_rise  <= vs_q & ~vs_d;
    end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: VGA sink that rebuilds pixel coordinates, writes a linear frame buffer and checks geometry (option: VGA_CAPTURE_CKSUM_EN)
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output pixel_t            wr_data,
  output logic              locked,
  output logic              frame_done,
  output logic              frame_err,
  output logic [31:0]       frame_cksum
);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  cap_state_t state, nstate;
  logic [10:0] x, y, nx, ny;
  logic [ADDR_W-1:0] addr, naddr;
  pixel_t pix;
  logic vld, vld_rise, vld_fall, hs_rise, sof, hs_err, we, done, err, nlocked;
`ifdef VGA_CAPTURE_CKSUM_EN
  logic [31:0] sum, nsum;
`endif

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_edge (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .pix_in({vga_r, vga_g, vga_b}), .pix(pix), .vld(vld), .vld_rise(vld_rise),
    .vld_fall(vld_fall), .hs_rise(hs_rise), .vs_rise(sof)
  );

  assign hs_err = hs_rise & vld;

  // next state: frame check at SOF, line check at valid fall, pixel counting in CAPTURE
  always_comb begin
    nstate = state;
    nx = x;
    ny = y;
    naddr = addr;
    we = 1'b0;
    done = 1'b0;
    err = 1'b0;
`ifdef VGA_CAPTURE_CKSUM_EN
    nsum = sum;
`endif
    if (sof) begin
      nstate = ARMED;
      nx = '0;
      ny = '0;
      naddr = '0;
      done = state == ARMED && y == VA;
      err = state == CAPTURE || (state == ARMED && y != VA);
`ifdef VGA_CAPTURE_CKSUM_EN
      nsum = '0;
`endif
    end else if (state == ARMED && vld_rise) nstate = CAPTURE;
    else if (state == CAPTURE && vld_fall) begin
      nx = '0;
      ny = x == HA ? sat_inc(y) : y;
      err = x != HA;
      nstate = x == HA ? ARMED : SEEK;
    end
    if (hs_err) begin
      err = 1'b1;
      nstate = SEEK;
    end
    if (nstate == CAPTURE && vld) begin
      we = x < HA && y < VA;
      nx = sat_inc(x);
      naddr = we ? addr + ADDR_W'(1) : addr;
`ifdef VGA_CAPTURE_CKSUM_EN
      nsum = we ? nsum + 32'(pix[23:16]) + 32'(pix[15:8]) + 32'(pix[7:0]) : nsum;
`endif
    end
    done = done & ~err;
    nlocked = err ? 1'b0 : done ? 1'b1 : locked;
  end

  // state, counters and registered frame-buffer / status outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= SEEK;
      x <= '0;
      y <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      locked <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= nstate;
      x <= nx;
      y <= ny;
      addr <= naddr;
      wr_en <= we;
      wr_addr <= addr;
      wr_data <= pix;
      locked <= nlocked;
      frame_done <= done;
      frame_err <= err;
    end

`ifdef VGA_CAPTURE_CKSUM_EN
  // running pixel sum; the finished frame's sum is latched alongside frame_done
  always_ff @(posedge clk)
    if (reset) begin
      sum <= '0;
      frame_cksum <= '0;
    end else begin
      sum <= nsum;
      if (done) frame_cksum <= sum;
    end
`else
  assign frame_cksum = 32'd0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames on a reduced 8x4 geometry covering capture, geometry errors, reset and early SOF
module tb_vga_capture;
  import vga_pkg::*;
  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 6;
  logic clk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic wr_en, locked, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  pixel_t wr_data;
  logic [31:0] frame_cksum;
  int n_cmp = 0, n_bad = 0, wn = 0, done_n = 0, err_n = 0, both_n = 0;
  logic [29:0] wlog [0:1023];

  always #5 clk = ~clk;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SYNC_POL(1'b0)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cksum(frame_cksum)
  );

  // log writes and count status pulses away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      wlog[wn[9:0]] <= {wr_addr, wr_data};
      wn <= wn + 1;
    end
    if (frame_done) done_n <= done_n + 1;
    if (frame_err) err_n <= err_n + 1;
    if (frame_done && frame_err) both_n <= both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic pixel_t px(input int x, input int y);
    return {8'(y), 8'(x), 8'h5A};
  endfunction

  function automatic logic [31:0] cks_exp();
    logic [31:0] s = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) s += 32'(y) + 32'(x) + 32'h5A;
    return s;
  endfunction

  task automatic cyc(input logic h, input logic vs, input logic vl, input pixel_t p);
    hsync = h;
    vsync = vs;
    valid = vl;
    {vga_r, vga_g, vga_b} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic line(input int y, input int n);
    for (int x = 0; x < n; x++) cyc(1'b1, 1'b1, 1'b1, px(x, y));
    blank();
  endtask

  task automatic lines(input int nl, input int bad_y, input int bad_n);
    for (int y = 0; y < nl; y++) line(y, y == bad_y ? bad_n : H);
  endtask

  task automatic vpulse();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic check_writes(input string tag, input int w0, input int n);
    chk({tag, "_cnt"}, 32'(wn - w0), 32'(n));
    for (int i = 0; i < n && w0 + i < wn; i++) begin
      chk({tag, "_addr"}, 32'(wlog[w0 + i][29:24]), 32'(i));
      chk({tag, "_data"}, 32'(wlog[w0 + i][23:0]), 32'(px(i % H, i / H)));
    end
  endtask

  initial begin
    int w0, d0, e0;
    logic [31:0] ck;
`ifdef VGA_CAPTURE_CKSUM_EN
    ck = cks_exp();
`else
    ck = 32'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_cksum", frame_cksum, 0);
    reset = 1'b0;
    // full frame, completed by the second SOF
    vpulse();
    w0 = wn;
    lines(V, -1, 0);
    check_writes("t1", w0, H * V);
    d0 = done_n;
    e0 = err_n;
    vpulse();
    chk("t1_done", 32'(done_n - d0), 1);
    chk("t1_err", 32'(err_n - e0), 0);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_cksum", frame_cksum, ck);
    // short line 1
    w0 = wn;
    d0 = done_n;
    e0 = err_n;
    lines(2, 1, H - 1);
    chk("t2_err", 32'(err_n - e0), 1);
    chk("t2_locked", 32'(locked), 0);
    line(2, H);
    line(3, H);
    check_writes("t2", w0, 2 * H - 1);
    vpulse();
    chk("t2_nodone", 32'(done_n - d0), 0);
    chk("t2_err_total", 32'(err_n - e0), 1);
    w0 = wn;
    lines(V, -1, 0);
    vpulse();
    chk("t2_done", 32'(done_n - d0), 1);
    chk("t2_locked2", 32'(locked), 1);
    check_writes("t2b", w0, H * V);
    // one line too many
    w0 = wn;
    d0 = done_n;
    e0 = err_n;
    lines(V + 1, -1, 0);
    check_writes("t3", w0, H * V);
    vpulse();
    chk("t3_err", 32'(err_n - e0), 1);
    chk("t3_nodone", 32'(done_n - d0), 0);
    chk("t3_locked", 32'(locked), 0);
    lines(V, -1, 0);
    vpulse();
    chk("t4_pre_locked", 32'(locked), 1);
    // reset in the middle of line 2
    lines(2, -1, 0);
    for (int x = 0; x < 3; x++) cyc(1'b1, 1'b1, 1'b1, px(x, 2));
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, px(3, 2));
    chk("t4_wr_en", 32'(wr_en), 0);
    chk("t4_locked", 32'(locked), 0);
    chk("t4_addr", 32'(wr_addr), 0);
    chk("t4_data", 32'(wr_data), 0);
    w0 = wn;
    reset = 1'b0;
    for (int x = 4; x < H; x++) cyc(1'b1, 1'b1, 1'b1, px(x, 2));
    blank();
    line(3, H);
    chk("t4_nowr", 32'(wn - w0), 0);
    vpulse();
    w0 = wn;
    d0 = done_n;
    lines(V, -1, 0);
    vpulse();
    chk("t4_done", 32'(done_n - d0), 1);
    check_writes("t4", w0, H * V);
    // vsync arriving while valid is high
    line(0, H);
    for (int x = 0; x < 4; x++) cyc(1'b1, 1'b1, 1'b1, px(x, 1));
    d0 = done_n;
    e0 = err_n;
    for (int x = 4; x < H; x++) cyc(1'b1, 1'b0, 1'b1, px(x, 1));
    blank();
    chk("t5_err", 32'(err_n - e0), 1);
    chk("t5_nodone", 32'(done_n - d0), 0);
    chk("t5_locked", 32'(locked), 0);
    w0 = wn;
    lines(V, -1, 0);
    check_writes("t5", w0, H * V);
    vpulse();
    chk("t5_done", 32'(done_n - d0), 1);
    chk("t5_cksum", frame_cksum, ck);
    chk("excl", 32'(both_n), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
